mem_arbiter: RTL and testbench

Two-requester arbiter/sequencer for the single shared memory port of the MiniSRC system. It sits between the processor's memory interface and the memory model/RAM, alongside a second master (program loader / debug port) that must share the same memory. It registers one transaction at a time, drives the memory strobes, waits on the memory ready handshake with a timeout, and returns data plus a one-cycle ready pulse to the granted requester. Grants are round-robin under contention.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin sequencer for the shared memory port
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic [AW-1:0] iP_Addr,
    input  logic [DW-1:0] iP_Data,
    input  logic          iP_Read,
    input  logic          iP_Write,
    output logic [DW-1:0] oP_Data,
    output logic          oP_Rdy,
    output logic          oP_Err,
    input  logic [AW-1:0] iD_Addr,
    input  logic [DW-1:0] iD_Data,
    input  logic          iD_Read,
    input  logic          iD_Write,
    output logic [DW-1:0] oD_Data,
    output logic          oD_Rdy,
    output logic          oD_Err,
    output logic [AW-1:0] oMemAddr,
    output logic [DW-1:0] oMemData,
    output logic          oMemRead,
    output logic          oMemWrite,
    input  logic [DW-1:0] iMemData,
    input  logic          iMemRdy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic            last_q;
    logic            gnt_q;
    logic            wr_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_data_q;
    logic            mem_rd_q;
    logic            mem_wr_q;
    logic [DW-1:0]   p_data_q;
    logic            p_rdy_q;
    logic            p_err_q;
    logic [DW-1:0]   d_data_q;
    logic            d_rdy_q;
    logic            d_err_q;

    logic            p_req;
    logic            d_req;
    logic            gnt_d;
    logic            wr_d;
    logic [AW-1:0]   addr_d;
    logic [DW-1:0]   wdata_d;
    logic [DW-1:0]   rdata_d;
    logic            done_d;
    logic            timeout_d;

    always_comb begin
        p_req   = iP_Read | iP_Write;
        d_req   = iD_Read | iD_Write;
        gnt_d   = d_req;
        // Under contention the requester not served last wins.
        if (p_req && d_req) begin
            gnt_d = ~last_q;
        end
        wr_d      = gnt_d ? iD_Write : iP_Write;
        addr_d    = gnt_d ? iD_Addr  : iP_Addr;
        wdata_d   = gnt_d ? iD_Data  : iP_Data;
        timeout_d = (cnt_q == CW'(TIMEOUT - 1));
        done_d    = iMemRdy | timeout_d;
        rdata_d   = (iMemRdy && !wr_q) ? iMemData : '0;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            p_data_q   <= '0;
            p_rdy_q    <= 1'b0;
            p_err_q    <= 1'b0;
            d_data_q   <= '0;
            d_rdy_q    <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            p_rdy_q <= 1'b0;
            p_err_q <= 1'b0;
            d_rdy_q <= 1'b0;
            d_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (p_req || d_req) begin
                        gnt_q      <= gnt_d;
                        wr_q       <= wr_d;
                        mem_addr_q <= addr_d;
                        mem_data_q <= wdata_d;
                        mem_rd_q   <= ~wr_d;
                        mem_wr_q   <= wr_d;
                        cnt_q      <= '0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (done_d) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        last_q   <= gnt_q;
                        state_q  <= DONE;
                        if (gnt_q) begin
                            d_data_q <= rdata_d;
                            d_rdy_q  <= 1'b1;
                            d_err_q  <= ~iMemRdy;
                        end else begin
                            p_data_q <= rdata_d;
                            p_rdy_q  <= 1'b1;
                            p_err_q  <= ~iMemRdy;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oMemAddr  = mem_addr_q;
    assign oMemData  = mem_data_q;
    assign oMemRead  = mem_rd_q;
    assign oMemWrite = mem_wr_q;
    assign oP_Data   = p_data_q;
    assign oP_Rdy    = p_rdy_q;
    assign oP_Err    = p_err_q;
    assign oD_Data   = d_data_q;
    assign oD_Rdy    = d_rdy_q;
    assign oD_Err    = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [31:0] iP_Addr, iP_Data, iD_Addr, iD_Data, iMemData;
    logic        iP_Read, iP_Write, iD_Read, iD_Write, iMemRdy;
    logic [31:0] oP_Data, oD_Data, oMemAddr, oMemData;
    logic        oP_Rdy, oP_Err, oD_Rdy, oD_Err, oMemRead, oMemWrite;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .iClk(iClk), .iRst(iRst),
        .iP_Addr(iP_Addr), .iP_Data(iP_Data), .iP_Read(iP_Read), .iP_Write(iP_Write),
        .oP_Data(oP_Data), .oP_Rdy(oP_Rdy), .oP_Err(oP_Err),
        .iD_Addr(iD_Addr), .iD_Data(iD_Data), .iD_Read(iD_Read), .iD_Write(iD_Write),
        .oD_Data(oD_Data), .oD_Rdy(oD_Rdy), .oD_Err(oD_Err),
        .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
        .iMemData(iMemData), .iMemRdy(iMemRdy)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        @(negedge iClk);
    endtask

    initial begin
        iRst = 1'b1;
        iP_Addr = '0; iP_Data = '0; iP_Read = 1'b0; iP_Write = 1'b0;
        iD_Addr = '0; iD_Data = '0; iD_Read = 1'b0; iD_Write = 1'b0;
        iMemData = '0; iMemRdy = 1'b0;
        tick();
        tick();
        chk("rst_memread", oMemRead, 1'b0);
        chk("rst_memwrite", oMemWrite, 1'b0);
        chk("rst_prdy", oP_Rdy, 1'b0);
        chk("rst_drdy", oD_Rdy, 1'b0);
        chk("rst_memaddr", oMemAddr, 32'h0);
        chk("rst_pdata", oP_Data, 32'h0);
        iRst = 1'b0;

        // single read, zero wait states
        iMemRdy = 1'b1; iMemData = 32'd10;
        iP_Addr = 32'h14; iP_Read = 1'b1;
        tick();
        chk("rd_memread", oMemRead, 1'b1);
        chk("rd_memwrite", oMemWrite, 1'b0);
        chk("rd_memaddr", oMemAddr, 32'h14);
        chk("rd_prdy_early", oP_Rdy, 1'b0);
        tick();
        chk("rd_prdy", oP_Rdy, 1'b1);
        chk("rd_pdata", oP_Data, 32'd10);
        chk("rd_perr", oP_Err, 1'b0);
        chk("rd_drdy", oD_Rdy, 1'b0);
        chk("rd_memread_off", oMemRead, 1'b0);
        iP_Read = 1'b0;
        tick();
        chk("rd_prdy_pulse", oP_Rdy, 1'b0);

        // write with three wait states
        iMemRdy = 1'b0;
        iD_Addr = 32'h40; iD_Data = 32'hDEADBEEF; iD_Write = 1'b1;
        tick();
        chk("wr_memdata", oMemData, 32'hDEADBEEF);
        chk("wr_memaddr", oMemAddr, 32'h40);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (oMemWrite) cnt++;
            tick();
        end
        if (oMemWrite) cnt++;
        iMemRdy = 1'b1; iMemData = 32'h1234;
        tick();
        chk("wr_strobe_cycles", cnt, 4);
        chk("wr_memwrite_off", oMemWrite, 1'b0);
        chk("wr_drdy", oD_Rdy, 1'b1);
        chk("wr_derr", oD_Err, 1'b0);
        chk("wr_ddata", oD_Data, 32'h0);
        chk("wr_prdy", oP_Rdy, 1'b0);
        chk("wr_pdata_hold", oP_Data, 32'd10);
        iD_Write = 1'b0;
        tick();
        chk("wr_drdy_pulse", oD_Rdy, 1'b0);

        // contention: P then D alternating, 3-cycle spacing
        iMemRdy = 1'b1;
        iP_Addr = 32'h100; iP_Read = 1'b1;
        iD_Addr = 32'h200; iD_Read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iMemData = 32'h1000 + i;
            tick();
            chk("ct_addr", oMemAddr, (i % 2 == 0) ? 32'h100 : 32'h200);
            chk("ct_memread", oMemRead, 1'b1);
            tick();
            chk("ct_prdy", oP_Rdy, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("ct_drdy", oD_Rdy, (i % 2 == 0) ? 1'b0 : 1'b1);
            if (i % 2 == 0) begin
                chk("ct_pdata", oP_Data, 32'h1000 + i);
                iP_Read = 1'b0;
            end else begin
                chk("ct_ddata", oD_Data, 32'h1000 + i);
                iD_Read = 1'b0;
            end
            tick();
            chk("ct_idle_rdy", {oP_Rdy, oD_Rdy}, 2'b00);
            if (i < 3) begin
                if (i % 2 == 0) iP_Read = 1'b1;
                else            iD_Read = 1'b1;
            end
        end
        iP_Read = 1'b0; iD_Read = 1'b0;

        // timeout on a P read
        iMemRdy = 1'b0; iMemData = 32'hFF;
        iP_Addr = 32'h80; iP_Read = 1'b1;
        tick();
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!oMemRead) break;
            cnt++;
            tick();
        end
        chk("to_strobe_cycles", cnt, 16);
        chk("to_prdy", oP_Rdy, 1'b1);
        chk("to_perr", oP_Err, 1'b1);
        chk("to_pdata", oP_Data, 32'h0);
        chk("to_drdy", oD_Rdy, 1'b0);
        iP_Read = 1'b0;
        tick();
        chk("to_perr_pulse", oP_Err, 1'b0);

        // reset during second wait cycle of a D read
        iD_Addr = 32'h300; iD_Read = 1'b1;
        tick();
        tick();
        chk("rb_memread", oMemRead, 1'b1);
        iRst = 1'b1;
        tick();
        chk("rb_memread_off", oMemRead, 1'b0);
        chk("rb_drdy", oD_Rdy, 1'b0);
        chk("rb_derr", oD_Err, 1'b0);
        chk("rb_memaddr", oMemAddr, 32'h0);
        iRst = 1'b0; iD_Read = 1'b0;
        tick();
        chk("rb_drdy_after", oD_Rdy, 1'b0);
        iMemRdy = 1'b1; iMemData = 32'h55;
        iP_Addr = 32'h500; iP_Read = 1'b1;
        iD_Addr = 32'h600; iD_Read = 1'b1;
        tick();
        chk("rb_grant_p", oMemAddr, 32'h500);
        tick();
        chk("rb_prdy", oP_Rdy, 1'b1);
        chk("rb_pdata", oP_Data, 32'h55);
        iP_Read = 1'b0; iD_Read = 1'b0;
        tick();

        // read and write together from D is a write
        iD_Addr = 32'h44; iD_Data = 32'd5; iD_Read = 1'b1; iD_Write = 1'b1;
        iMemData = 32'h77;
        tick();
        chk("rw_memwrite", oMemWrite, 1'b1);
        chk("rw_memread", oMemRead, 1'b0);
        chk("rw_memdata", oMemData, 32'd5);
        tick();
        chk("rw_drdy", oD_Rdy, 1'b1);
        chk("rw_ddata", oD_Data, 32'h0);
        iD_Read = 1'b0; iD_Write = 1'b0;
        tick();
        chk("rw_idle", {oMemRead, oMemWrite, oD_Rdy}, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
